pipe_stage: RTL and testbench

PIPE_STAGE -- requirements
Module: pipe_stage

---
 rtl/pipe_stage.sv | 123 ++++++++++++
 tb/tb_pipe_stage.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage.sv
// Pipeline register stage with valid/ready handshake, optional two-entry skid
// buffer, flush, bubble control masking and a saturating back-pressure counter.
module pipe_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 12,
  parameter int SKID   = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [15:0]       stall_cnt,
  input  logic              clr_cnt
);

  // State bits are {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t              r_state, w_state_n;
  logic [CTRL_W-1:0]   r_main_ctrl, r_skid_ctrl;
  logic [DATA_W-1:0]   r_main_data, r_skid_data;
  logic [15:0]         r_stall;
  logic                w_vm, w_vs;
  logic                w_in_xfer, w_out_xfer;
  logic                w_ld_main, w_ld_skid, w_skid_to_main;

  assign w_vm = r_state[0];
  assign w_vs = r_state[1];

  // Gating with reset keeps in_ready low while reset is held.
  assign in_ready   = ~reset & ((SKID != 0) ? ~w_vs : (~w_vm | out_ready));
  assign w_in_xfer  = in_valid & in_ready;
  assign w_out_xfer = w_vm & out_ready;

  always_comb begin
    w_state_n      = r_state;
    w_ld_main      = 1'b0;
    w_ld_skid      = 1'b0;
    w_skid_to_main = 1'b0;
    if (flush) begin
      w_state_n = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_xfer) begin
            w_state_n = ONE;
            w_ld_main = 1'b1;
          end
        end
        ONE: begin
          // Without a skid entry, in-without-out cannot happen (in_ready low).
          if (w_in_xfer && w_out_xfer) begin
            w_ld_main = 1'b1;
          end else if (w_in_xfer && (SKID != 0)) begin
            w_state_n = FULL;
            w_ld_skid = 1'b1;
          end else if (w_out_xfer) begin
            w_state_n = EMPTY;
          end
        end
        FULL: begin
          if (w_out_xfer) begin
            w_state_n      = ONE;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_state_n = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= EMPTY;
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else begin
      r_state <= w_state_n;
      if (w_ld_main) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_skid_to_main) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_ld_skid) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_stall <= '0;
    end else if (clr_cnt) begin
      r_stall <= '0;
    end else if (w_vm && !out_ready && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign out_valid = w_vm;
  assign out_ctrl  = w_vm ? r_main_ctrl : '0;
  assign out_data  = r_main_data;
  assign occupancy = {1'b0, w_vm} + {1'b0, w_vs};
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: one SKID=1 and one SKID=0 instance, each checked every
// cycle against a FIFO-style reference model, plus directed literal scenarios.
module tb_pipe_stage;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  // Index 1 = SKID=1 instance, index 0 = SKID=0 instance.
  logic [1:0]        in_valid, out_ready, flush, clr_cnt;
  logic [1:0][11:0]  in_ctrl;
  logic [1:0][31:0]  in_data;
  logic [1:0]        in_ready, out_valid;
  logic [1:0][11:0]  out_ctrl;
  logic [1:0][31:0]  out_data;
  logic [1:0][1:0]   occupancy;
  logic [1:0][15:0]  stall_cnt;

  pipe_stage #(.DATA_W(32), .CTRL_W(12), .SKID(1)) u_s1 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_ctrl(in_ctrl[1]), .in_data(in_data[1]), .flush(flush[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_ctrl(out_ctrl[1]), .out_data(out_data[1]),
    .occupancy(occupancy[1]), .stall_cnt(stall_cnt[1]), .clr_cnt(clr_cnt[1])
  );

  pipe_stage #(.DATA_W(32), .CTRL_W(12), .SKID(0)) u_s0 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_ctrl(in_ctrl[0]), .in_data(in_data[0]), .flush(flush[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_ctrl(out_ctrl[0]), .out_data(out_data[0]),
    .occupancy(occupancy[0]), .stall_cnt(stall_cnt[0]), .clr_cnt(clr_cnt[0])
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a FIFO of up to 2 entries per instance, entry 0 = head.
  logic [11:0] m_ctrl [2][2];
  logic [31:0] m_data [2][2];
  int          m_cnt  [2];
  int          m_stall[2];

  function automatic logic model_ir(input int k);
    if (reset) return 1'b0;
    if (k == 1) return m_cnt[1] < 2;
    return (m_cnt[0] == 0) || out_ready[0];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]   = 0;
      m_stall[k] = 0;
    end
  endtask

  task automatic model_step();
    logic ir;
    for (int k = 0; k < 2; k++) begin
      ir = model_ir(k);
      if (clr_cnt[k]) m_stall[k] = 0;
      else if (m_cnt[k] > 0 && !out_ready[k] && m_stall[k] < 65535) m_stall[k]++;
      if (flush[k]) begin
        m_cnt[k] = 0;
      end else begin
        if (m_cnt[k] > 0 && out_ready[k]) begin
          m_ctrl[k][0] = m_ctrl[k][1];
          m_data[k][0] = m_data[k][1];
          m_cnt[k]--;
        end
        if (in_valid[k] && ir) begin
          m_ctrl[k][m_cnt[k]] = in_ctrl[k];
          m_data[k][m_cnt[k]] = in_data[k];
          m_cnt[k]++;
        end
      end
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clock);
      if (reset) model_clear();
      else model_step();
    end
  end

  initial forever begin
    @(posedge reset);
    model_clear();
  end

  // Compare process: every negedge, both instances against the model.
  initial forever begin
    @(negedge clock);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(m_cnt[k] > 0));
      chk($sformatf("in_ready[%0d]", k), 64'(in_ready[k]), 64'(model_ir(k)));
      chk($sformatf("occupancy[%0d]", k), 64'(occupancy[k]), 64'(m_cnt[k]));
      chk($sformatf("out_ctrl[%0d]", k), 64'(out_ctrl[k]),
          (m_cnt[k] > 0) ? 64'(m_ctrl[k][0]) : 64'd0);
      chk($sformatf("stall_cnt[%0d]", k), 64'(stall_cnt[k]), 64'(m_stall[k]));
      if (reset) chk($sformatf("out_data_rst[%0d]", k), 64'(out_data[k]), 64'd0);
      else if (m_cnt[k] > 0)
        chk($sformatf("out_data[%0d]", k), 64'(out_data[k]), 64'(m_data[k][0]));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = '0; out_ready = '0; flush = '0; clr_cnt = '0;
    in_ctrl = '0; in_data = '0;
  endtask

  initial begin
    idle_inputs();
    repeat (3) @(posedge clock);
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'b11);

    // Streaming at full rate through the skid instance.
    out_ready[1] = 1'b1; in_valid[1] = 1'b1; in_ctrl[1] = 12'h5A0;
    for (int i = 1; i <= 3; i++) begin
      in_data[1] = 32'(i);
      tick();
      chk("stream_data", 64'(out_data[1]), 64'(i));
      chk("stream_ready", 64'(in_ready[1]), 64'd1);
      chk("stream_occ", 64'(occupancy[1]), 64'd1);
    end
    in_valid[1] = 1'b0;
    tick();
    chk("stream_drain", 64'(out_valid[1]), 64'd0);
    chk("stream_stall", 64'(stall_cnt[1]), 64'd0);

    // Back-pressure: A, B fill the stage, C waits upstream.
    out_ready[1] = 1'b0; in_valid[1] = 1'b1; in_data[1] = 32'hA;
    tick();
    chk("bp_occ1", 64'(occupancy[1]), 64'd1);
    in_data[1] = 32'hB;
    tick();
    chk("bp_occ2", 64'(occupancy[1]), 64'd2);
    chk("bp_ready0", 64'(in_ready[1]), 64'd0);
    in_data[1] = 32'hC;
    tick();
    chk("bp_hold_occ", 64'(occupancy[1]), 64'd2);
    chk("bp_head_A", 64'(out_data[1]), 64'hA);
    chk("bp_stall", 64'(stall_cnt[1]), 64'd2);
    out_ready[1] = 1'b1;
    tick();
    chk("bp_head_B", 64'(out_data[1]), 64'hB);
    chk("bp_occ_after", 64'(occupancy[1]), 64'd1);
    tick();
    chk("bp_head_C", 64'(out_data[1]), 64'hC);
    chk("bp_ctrl", 64'(out_ctrl[1]), 64'h5A0);
    in_valid[1] = 1'b0;
    tick();
    chk("bp_empty", 64'(occupancy[1]), 64'd0);
    chk("bp_stall_final", 64'(stall_cnt[1]), 64'd2);

    // Single-entry instance: combinational ready and replace-on-transfer.
    out_ready[0] = 1'b0; in_valid[0] = 1'b1; in_data[0] = 32'hA; in_ctrl[0] = 12'h0F1;
    tick();
    chk("s0_head_A", 64'(out_data[0]), 64'hA);
    chk("s0_ready0", 64'(in_ready[0]), 64'd0);
    out_ready[0] = 1'b1; in_data[0] = 32'hB;
    #1;
    chk("s0_ready_comb", 64'(in_ready[0]), 64'd1);
    tick();
    chk("s0_head_B", 64'(out_data[0]), 64'hB);
    chk("s0_occ", 64'(occupancy[0]), 64'd1);
    in_valid[0] = 1'b0;
    tick();
    chk("s0_empty", 64'(out_valid[0]), 64'd0);

    // Flush while FULL with a concurrent input.
    out_ready[1] = 1'b0; in_valid[1] = 1'b1; in_data[1] = 32'h11;
    tick();
    in_data[1] = 32'h22;
    tick();
    chk("fl_full", 64'(occupancy[1]), 64'd2);
    flush[1] = 1'b1; in_data[1] = 32'hDD;
    tick();
    flush[1] = 1'b0; in_valid[1] = 1'b0;
    chk("fl_valid", 64'(out_valid[1]), 64'd0);
    chk("fl_ctrl", 64'(out_ctrl[1]), 64'd0);
    chk("fl_occ", 64'(occupancy[1]), 64'd0);
    chk("fl_ready", 64'(in_ready[1]), 64'd1);
    out_ready[1] = 1'b1;
    tick();
    chk("fl_no_ghost", 64'(out_valid[1]), 64'd0);

    // Saturation of stall counter, then clear.
    clr_cnt[1] = 1'b1;
    tick();
    clr_cnt[1] = 1'b0; out_ready[1] = 1'b0; in_valid[1] = 1'b1; in_data[1] = 32'h77;
    tick();
    in_valid[1] = 1'b0;
    repeat (70000) tick();
    chk("sat_stall", 64'(stall_cnt[1]), 64'hFFFF);
    clr_cnt[1] = 1'b1;
    tick();
    clr_cnt[1] = 1'b0;
    chk("sat_clear", 64'(stall_cnt[1]), 64'd0);

    // Asynchronous reset mid-cycle while FULL.
    in_valid[1] = 1'b1; in_data[1] = 32'h88;
    tick();
    in_valid[1] = 1'b0;
    chk("ar_full", 64'(occupancy[1]), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 64'(out_valid[1]), 64'd0);
    chk("ar_occ", 64'(occupancy[1]), 64'd0);
    chk("ar_data", 64'(out_data[1]), 64'd0);
    chk("ar_ctrl", 64'(out_ctrl[1]), 64'd0);
    chk("ar_stall", 64'(stall_cnt[1]), 64'd0);
    chk("ar_ready", 64'(in_ready[1]), 64'd0);
    tick();
    #2;
    reset = 1'b0;
    out_ready = 2'b11;
    #1;
    chk("ar_release_ready", 64'(in_ready[1]), 64'd1);
    tick();
    chk("ar_no_emit", 64'(out_valid[1]), 64'd0);

    // Randomized traffic on both instances.
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < 2; k++) begin
        in_valid[k]  = ($urandom_range(0, 3) != 0);
        out_ready[k] = ($urandom_range(0, 2) != 0);
        flush[k]     = ($urandom_range(0, 19) == 0);
        clr_cnt[k]   = ($urandom_range(0, 49) == 0);
        in_ctrl[k]   = 12'($urandom);
        in_data[k]   = $urandom;
      end
      tick();
    end
    idle_inputs();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
